// File: rtl/zip_stream_arbiter.sv
// zip_stream_arbiter: packet round-robin of two IQ streams into the 4:1 packer, keeping packets group-aligned.
// Define ZIP_ARB_PAD_EN to zero-pad misaligned packets up to a whole group.
module zip_stream_arbiter #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i0_tdata,
  input  logic             i0_tlast,
  input  logic             i0_tvalid,
  output logic             i0_tready,
  input  logic [WIDTH-1:0] i1_tdata,
  input  logic             i1_tlast,
  input  logic             i1_tvalid,
  output logic             i1_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_src,
  output logic             misalign
);
  localparam int PW = $clog2(GROUP);
`ifdef ZIP_ARB_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;
  state_t state, state_n;
  logic sel, last, req, grant, in_valid, in_last, aligned, hs;
  logic [PW-1:0] phase;
  always_comb begin
    req = i0_tvalid || i1_tvalid;
    grant = (i0_tvalid && i1_tvalid) ? ~last : i1_tvalid;
    in_valid = sel ? i1_tvalid : i0_tvalid;
    in_last = sel ? i1_tlast : i0_tlast;
    aligned = phase == PW'(GROUP - 1);
    hs = o_tvalid && o_tready;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      sel <= 1'b0;
      last <= 1'b1;
      phase <= '0;
      misalign <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        sel <= grant;
        phase <= '0;
      end else if (hs) phase <= phase + 1'b1;
      if (state != IDLE && state_n == IDLE) last <= sel;
      if (state == PASS && hs && in_last && !aligned) misalign <= 1'b1;
    end
  // A misaligned tlast only detours through PAD when padding is built in.
  always_comb
    state_n = state == IDLE ? (req ? PASS : IDLE)
            : state == PASS ? ((hs && in_last) ? ((aligned || !PAD_EN) ? IDLE : PAD) : PASS)
            : ((hs && aligned) ? IDLE : PAD);
  always_comb begin
    o_tvalid = state == PAD || (state == PASS && in_valid);
    o_tdata = state == PASS ? (sel ? i1_tdata : i0_tdata) : '0;
    o_tlast = state == PAD ? aligned : (state == PASS && in_last && (aligned || !PAD_EN));
    i0_tready = state == PASS && !sel && o_tready;
    i1_tready = state == PASS && sel && o_tready;
    o_src = state != IDLE && sel;
  end
endmodule

// File: doc/zip_stream_arbiter.md
# zip_stream_arbiter

Packet-granular round-robin arbiter sharing the 4:1 sample-packing compressor between two 32-bit IQ sample streams. It forwards whole packets from one requester at a time and guarantees that every forwarded packet holds a whole number of packing groups of GROUP samples. A packer downstream therefore never produces a word that mixes samples from two sources. It sits directly upstream of the packer in the QPSK receive chain.

## Interface
Parameters:
- WIDTH, 32, sample width (16-bit I in [31:16], 16-bit Q in [15:0])
- GROUP, 4, samples per packed output word of the downstream packer; power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i0_tdata  in  WIDTH  requester 0 sample
- i0_tlast  in  1  requester 0 end of packet
- i0_tvalid  in  1  requester 0 valid
- i0_tready  out  1  requester 0 ready
- i1_tdata / i1_tlast / i1_tvalid / i1_tready  same as above, for requester 1
- o_tdata  out  WIDTH  sample to packer
- o_tlast  out  1  end of packet to packer
- o_tvalid  out  1  output valid
- o_tready  in  1  packer ready
- o_src  out  1  index of the granted requester; meaningful while o_tvalid=1
- misalign  out  1  sticky flag: a packet ended with a partial group (phase ≠ GROUP-1)

One clock; reset is synchronous and active-high.

## Operation
- State machine with three states: IDLE, PASS, PAD.
- Internal registers:
  - sel: granted requester index.
  - last: last requester served; reset value 1, so requester 0 wins first.
  - phase: sample position within the current group, 0..GROUP-1, wraps modulo GROUP.
- IDLE:
  - If exactly one iN_tvalid is high, that requester is granted.
  - If both are high, the requester ≠ last is granted.
  - On a grant: sel is loaded, phase is set to 0, and the state moves to PASS.
  - No data moves in IDLE: both treadys are 0 and o_tvalid is 0.
- PASS:
  - o_tdata, o_tlast and o_tvalid follow the granted input combinationally.
  - i[sel]_tready = o_tready; the other tready is 0.
  - Each handshake advances phase.
- Handshake carrying tlast with phase == GROUP-1: the packet is aligned.
  - o_tlast = 1.
  - last is set to sel, and the state returns to IDLE.
- Handshake carrying tlast with phase ≠ GROUP-1: misalign is set.
  - Further handling depends on the configuration; see Configuration.
- PAD:
  - o_tvalid = 1 and o_tdata = 0.
  - Both treadys are 0.
  - Each handshake advances phase.
  - On the handshake where phase == GROUP-1: o_tlast = 1, last is set to sel, and the state returns to IDLE.
- o_src = sel in PASS and PAD, and 0 in IDLE.
- misalign is cleared only by reset.

## Timing
- Reset values:
  - o_tvalid 0, o_tlast 0, o_tdata 0, o_src 0, i0_tready 0, i1_tready 0, misalign 0.
  - State IDLE, phase 0, last 1.
- Latency:
  - Data path in PASS: 0 cycles (combinational).
  - Arbitration: exactly one idle cycle between the tlast handshake and the first beat of the next packet.
- AXI-stream rules:
  - In PAD, o_tvalid stays high and o_tdata = 0 stays stable until accepted.
  - Treadys never depend on the non-granted input's tvalid.
- Back-pressure: with o_tready=0, no state, phase or last change occurs, and misalign is unchanged.
- Simultaneous request for a new packet on the tlast cycle: that request is not granted until the following IDLE cycle.
- Single-beat packet (tlast on phase 0) when GROUP>1: treated as misaligned.
- Reset asserted mid-packet:
  - The current packet is dropped and any pending pad is abandoned.
  - All registers return to reset values on the next edge.
  - The next grant goes to requester 0 if it is valid.

## Configuration
- ZIP_ARB_PAD_EN defined (padding on): a misaligned tlast beat is forwarded with o_tlast = 0. Phase advances and the state moves to PAD, which emits (GROUP-1-phase_at_tlast) zero samples, with tlast on the last one.
- ZIP_ARB_PAD_EN undefined (padding off):
  - A misaligned tlast beat is forwarded with o_tlast = 1; no padding is inserted.
  - The state returns to IDLE and last is set to sel.
  - The PAD state is unreachable.
  - misalign is still set.

## Test plan
- Reset, then i0 sends 8 beats (tlast on beat 8) with i1 idle → 8 beats out, o_src=0, o_tlast on beat 8 only, misalign=0.
- i0 and i1 both hold 4-beat packets continuously → output alternates 0,1,0,1 per packet, with one idle cycle between packets, and the first packet comes from i0.
- PAD_EN: i1 sends 5 beats, tlast on beat 5 (data 0x11110001..0x11110005) → output is those 5 beats followed by 3 beats of 0x00000000; o_tlast on beat 8 only; misalign=1.
- No PAD_EN, same stimulus → 5 beats out, o_tlast on beat 5, misalign=1, the next grant is i0.
- Random o_tready toggling (50%) during a 12-beat i0 packet → data order is intact, no beat is duplicated or lost, and tdata/tvalid stay stable while stalled.
- Reset pulsed on beat 3 of a 4-beat i1 packet while i0 is valid → all outputs are 0 after the edge; the next packet comes from i0 and starts at phase 0.
